// File: rtl/outintf_pkg_ne.sv
// Shared types and defaults for the outFIFO loader: state encoding and frame geometry.
package outintf_pkg_ne;

    localparam int KB_DEF          = 14;
    localparam int HDDW_DEF        = 32;
    localparam int UNLOADCOUNT_DEF = 17;
    localparam int WRPIPE_DEPTH    = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_EMPTY = 3'd1,
        ST_READ       = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_DONE       = 3'd4,
        ST_WAIT_ACK   = 3'd5
    } load_state_t;

    function automatic logic state_busy(input load_state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/outload_wrpipe_ne.sv
// Write-side delay line: valid/address shift register plus a data capture register.
// DEPTH = HD memory read latency + 1 output register; DEPTH must be at least 2.
module outload_wrpipe_ne
    import outintf_pkg_ne::*;
#(
    parameter int DEPTH = WRPIPE_DEPTH,
    parameter int AW    = 5,
    parameter int DW    = KB_DEF * HDDW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld_in,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] din,
    output logic          vld_out,
    output logic [AW-1:0] addr_out,
    output logic [DW-1:0] dout,
    output logic          stage_busy
);

    logic [DEPTH-1:0] vld_reg;
    logic [DEPTH-1:0] vld_next;
    logic [AW-1:0]    addr_reg  [DEPTH];
    logic [AW-1:0]    addr_next [DEPTH];
    logic [DW-1:0]    dout_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign vld_next[gi]  = vld_in;
                assign addr_next[gi] = addr_in;
            end else begin : g_tail
                assign vld_next[gi]  = vld_reg[gi-1];
                assign addr_next[gi] = addr_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_reg[i] <= '0;
            end
        end else begin
            vld_reg  <= vld_next;
            addr_reg <= addr_next;
        end
    end

    // Memory data is valid while the row sits in the second-to-last stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_reg <= '0;
        end else if (vld_reg[DEPTH-2]) begin
            dout_reg <= din;
        end
    end

    assign vld_out    = vld_reg[DEPTH-1];
    assign addr_out   = addr_reg[DEPTH-1];
    assign dout       = dout_reg;
    assign stage_busy = |vld_reg[DEPTH-2:0];

endmodule

// File: rtl/outfifo_load_fsm_ne.sv
// Loads one decoded frame from HD memory into the output FIFO, then starts FIFO read-out.
// Optional macro OUTLOAD_OVERRUN_DET_EN enables the sticky dropped-frame (overrun) flag.
module outfifo_load_fsm_ne
    import outintf_pkg_ne::*;
#(
    parameter int KB           = KB_DEF,
    parameter int HDDW         = HDDW_DEF,
    parameter int UNLOADCOUNT  = UNLOADCOUNT_DEF,
    parameter int ADDRESSWIDTH = 5,
    parameter int HDADDRWIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    siso_ready,
    input  logic                    fifo_empty,
    input  logic [KB*HDDW-1:0]      HD_in,
    output logic                    hd_rd_en,
    output logic [HDADDRWIDTH-1:0]  hd_rd_addr,
    output logic [KB*HDDW-1:0]      WRDIN_kb,
    output logic [ADDRESSWIDTH-1:0] WA,
    output logic                    wr_en,
    output logic                    rd_en,
    output logic                    busy,
    output logic                    overrun
);

    localparam logic [HDADDRWIDTH-1:0] LAST_ROW = HDADDRWIDTH'(UNLOADCOUNT - 1);

    load_state_t            state_reg;
    logic                   pending_reg;
    logic [HDADDRWIDTH-1:0] rdcnt_reg;
    logic                   start_read;
    logic                   pipe_busy;
    logic                   last_wr;

    assign start_read = fifo_empty &&
                        (((state_reg == ST_IDLE) && pending_reg) || (state_reg == ST_WAIT_EMPTY));
    assign last_wr    = wr_en && !pipe_busy;
    assign busy       = state_busy(state_reg);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            pending_reg <= 1'b0;
            rdcnt_reg   <= '0;
            hd_rd_en    <= 1'b0;
            hd_rd_addr  <= '0;
            rd_en       <= 1'b0;
        end else begin
            // A frame arriving on the same edge as the clear stays queued.
            pending_reg <= siso_ready | (pending_reg & ~start_read);
            hd_rd_en    <= 1'b0;
            rd_en       <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_WAIT_EMPTY: begin
                    if (start_read) begin
                        state_reg  <= ST_READ;
                        rdcnt_reg  <= '0;
                        hd_rd_en   <= 1'b1;
                        hd_rd_addr <= '0;
                    end else if (pending_reg) begin
                        state_reg <= ST_WAIT_EMPTY;
                    end
                end
                ST_READ: begin
                    if (rdcnt_reg == LAST_ROW) begin
                        state_reg  <= ST_DRAIN;
                        rdcnt_reg  <= '0;
                        hd_rd_addr <= '0;
                    end else begin
                        rdcnt_reg  <= rdcnt_reg + 1'b1;
                        hd_rd_en   <= 1'b1;
                        hd_rd_addr <= rdcnt_reg + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (last_wr) begin
                        state_reg <= ST_DONE;
                        rd_en     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // Empty only drops once the FIFO has latched rd_en; reloading before that would double-load.
                    if (!fifo_empty) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    outload_wrpipe_ne #(
        .DEPTH (WRPIPE_DEPTH),
        .AW    (ADDRESSWIDTH),
        .DW    (KB*HDDW)
    ) u_wrpipe (
        .clk        (clk),
        .rst        (rst),
        .vld_in     (hd_rd_en),
        .addr_in    (ADDRESSWIDTH'(hd_rd_addr)),
        .din        (HD_in),
        .vld_out    (wr_en),
        .addr_out   (WA),
        .dout       (WRDIN_kb),
        .stage_busy (pipe_busy)
    );

`ifdef OUTLOAD_OVERRUN_DET_EN
    logic overrun_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun_reg <= 1'b0;
        end else if (siso_ready && pending_reg && !start_read) begin
            overrun_reg <= 1'b1;
        end
    end

    assign overrun = overrun_reg;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_outfifo_load_fsm_ne.sv
// Scoreboard bench for outfifo_load_fsm_ne: directed frames, monitor checks writes, read starts and rd_en.
module tb_outfifo_load_fsm_ne;

    localparam int KB   = 14;
    localparam int HDDW = 32;
    localparam int UC   = 17;
    localparam int AW   = 5;
    localparam int HAW  = 5;
    localparam int DW   = KB * HDDW;
`ifdef OUTLOAD_OVERRUN_DET_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           siso_ready = 1'b0;
    logic           fifo_empty = 1'b1;
    logic [DW-1:0]  HD_in = '0;
    logic           hd_rd_en;
    logic [HAW-1:0] hd_rd_addr;
    logic [DW-1:0]  WRDIN_kb;
    logic [AW-1:0]  WA;
    logic           wr_en;
    logic           rd_en;
    logic           busy;
    logic           overrun;

    outfifo_load_fsm_ne #(
        .KB(KB), .HDDW(HDDW), .UNLOADCOUNT(UC), .ADDRESSWIDTH(AW), .HDADDRWIDTH(HAW)
    ) dut (
        .clk(clk), .rst(rst), .siso_ready(siso_ready), .fifo_empty(fifo_empty),
        .HD_in(HD_in), .hd_rd_en(hd_rd_en), .hd_rd_addr(hd_rd_addr),
        .WRDIN_kb(WRDIN_kb), .WA(WA), .wr_en(wr_en), .rd_en(rd_en),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    typedef struct {
        int            cyc;
        logic [AW-1:0] wa;
        logic [DW-1:0] data;
    } wr_exp_t;

    wr_exp_t exp_wr[$];
    int      exp_rd[$];
    int      exp_start[$];

    function automatic logic [DW-1:0] row_data(input int r);
        logic [DW-1:0]   d;
        logic [HDDW-1:0] lane;
        lane = HDDW'(32'h01010101 * r);
        for (int k = 0; k < KB; k++) d[k*HDDW +: HDDW] = lane;
        return d;
    endfunction

    // HD memory model: synchronous read, one cycle latency.
    always @(posedge clk) if (hd_rd_en) HD_in <= row_data(int'(hd_rd_addr));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, act, exp);
        end else begin
            $display("ok   %s @cyc %0d: %0h", name, cyc, act);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input int first, input int nwr, input bit with_rd);
        wr_exp_t w;
        exp_start.push_back(first);
        for (int k = 0; k < nwr; k++) begin
            w.cyc  = first + 2 + k;
            w.wa   = AW'(k);
            w.data = row_data(k);
            exp_wr.push_back(w);
        end
        if (with_rd) exp_rd.push_back(first + UC + 2);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    wr_exp_t mon_w;
    int      mon_e;
    always @(negedge clk) begin
        if (hd_rd_en && hd_rd_addr == '0) begin
            mon_e = (exp_start.size() > 0) ? exp_start.pop_front() : -1;
            check("read_start_cycle", 64'(cyc), 64'(mon_e));
        end
        if (wr_en) begin
            wr_cnt++;
            if (exp_wr.size() > 0) mon_w = exp_wr.pop_front();
            else begin
                mon_w.cyc = -1; mon_w.wa = '0; mon_w.data = '0;
            end
            n_cmp++;
            if (cyc != mon_w.cyc || WA !== mon_w.wa || WRDIN_kb !== mon_w.data) begin
                n_bad++;
                $display("FAIL write: got cyc=%0d WA=%0d data=%h, required cyc=%0d WA=%0d data=%h",
                         cyc, WA, WRDIN_kb, mon_w.cyc, mon_w.wa, mon_w.data);
            end else begin
                $display("ok   write cyc=%0d WA=%0d lane0=%h", cyc, WA, WRDIN_kb[HDDW-1:0]);
            end
        end
        if (rd_en) begin
            rd_cnt++;
            mon_e = (exp_rd.size() > 0) ? exp_rd.pop_front() : -1;
            check("rd_en_cycle", 64'(cyc), 64'(mon_e));
        end
    end

    // One frame with fifo_empty=1 at start, acknowledged by the FIFO a few cycles after rd_en.
    task automatic run_simple_frame();
        int s;
        s = cyc + 2;
        goto(s);
        siso_ready = 1'b1;
        push_frame(s + 2, UC, 1'b1);
        goto(s + 1);
        siso_ready = 1'b0;
        @(negedge clk) check("busy_while_pending", 64'(busy), 64'(0));
        goto(s + 2);
        @(negedge clk) check("busy_in_read", 64'(busy), 64'(1));
        goto(s + 24);
        fifo_empty = 1'b0;
        @(negedge clk) check("busy_wait_ack", 64'(busy), 64'(1));
        goto(s + 25);
        @(negedge clk) check("busy_after_ack", 64'(busy), 64'(0));
        goto(s + 30);
        fifo_empty = 1'b1;
        goto(s + 33);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int w0;
        int r0;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_hd_rd_en", 64'(hd_rd_en), 64'(0));
        check("rst_wr_en", 64'(wr_en), 64'(0));
        check("rst_rd_en", 64'(rd_en), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_WA", 64'(WA), 64'(0));
        check("rst_wrdin_nonzero", 64'(|WRDIN_kb), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic load
        run_simple_frame();

        // FIFO still transmitting when the frame arrives
        s = cyc + 2;
        goto(s);
        fifo_empty = 1'b0;
        siso_ready = 1'b1;
        push_frame(s + 51, UC, 1'b1);
        goto(s + 1);
        siso_ready = 1'b0;
        goto(s + 3);
        @(negedge clk) check("busy_wait_empty", 64'(busy), 64'(1));
        goto(s + 50);
        fifo_empty = 1'b1;
        @(negedge clk) check("no_read_before_release", 64'(hd_rd_en), 64'(0));
        goto(s + 73);
        fifo_empty = 1'b0;
        goto(s + 80);
        fifo_empty = 1'b1;
        goto(s + 83);

        // Back-to-back frames with WAIT_ACK guard (fifo_empty stays 1 for 3 cycles after rd_en)
        w0 = wr_cnt;
        r0 = rd_cnt;
        s = cyc + 2;
        goto(s);
        siso_ready = 1'b1;
        push_frame(s + 2, UC, 1'b1);
        goto(s + 1);
        siso_ready = 1'b0;
        goto(s + 6);
        siso_ready = 1'b1;
        push_frame(s + 36, UC, 1'b1);
        goto(s + 7);
        siso_ready = 1'b0;
        goto(s + 24);
        @(negedge clk) begin
            check("guard_busy", 64'(busy), 64'(1));
            check("guard_no_read", 64'(hd_rd_en), 64'(0));
            check("guard_no_rd_en", 64'(rd_en), 64'(0));
        end
        goto(s + 25);
        fifo_empty = 1'b0;
        goto(s + 35);
        fifo_empty = 1'b1;
        goto(s + 58);
        fifo_empty = 1'b0;
        goto(s + 65);
        fifo_empty = 1'b1;
        goto(s + 68);
        @(negedge clk) begin
            check("b2b_total_writes", 64'(wr_cnt - w0), 64'(2 * UC));
            check("b2b_rd_pulses", 64'(rd_cnt - r0), 64'(2));
            check("b2b_no_overrun", 64'(overrun), 64'(0));
        end

        // Reset in the middle of READ (rdcnt=8): 7 writes already issued, no rd_en
        s = cyc + 2;
        goto(s);
        siso_ready = 1'b1;
        push_frame(s + 2, 7, 1'b0);
        goto(s + 1);
        siso_ready = 1'b0;
        goto(s + 10);
        rst = 1'b0;
        goto(s + 11);
        rst = 1'b1;
        @(negedge clk) begin
            check("abort_hd_rd_en", 64'(hd_rd_en), 64'(0));
            check("abort_hd_rd_addr", 64'(hd_rd_addr), 64'(0));
            check("abort_wr_en", 64'(wr_en), 64'(0));
            check("abort_WA", 64'(WA), 64'(0));
            check("abort_wrdin_nonzero", 64'(|WRDIN_kb), 64'(0));
            check("abort_busy", 64'(busy), 64'(0));
        end
        goto(s + 16);
        @(negedge clk) check("abort_stays_idle", 64'(busy), 64'(0));
        run_simple_frame();

        // Three frame pulses during one load: the third is lost
        s = cyc + 2;
        goto(s);
        siso_ready = 1'b1;
        push_frame(s + 2, UC, 1'b1);
        goto(s + 1);
        siso_ready = 1'b0;
        goto(s + 4);
        siso_ready = 1'b1;
        goto(s + 5);
        siso_ready = 1'b0;
        @(negedge clk) check("overrun_second_pulse", 64'(overrun), 64'(0));
        goto(s + 7);
        siso_ready = 1'b1;
        push_frame(s + 36, UC, 1'b1);
        goto(s + 8);
        siso_ready = 1'b0;
        @(negedge clk) check("overrun_third_pulse", 64'(overrun), 64'(OVR_EXP));
        goto(s + 25);
        fifo_empty = 1'b0;
        goto(s + 35);
        fifo_empty = 1'b1;
        goto(s + 58);
        fifo_empty = 1'b0;
        goto(s + 65);
        fifo_empty = 1'b1;
        goto(s + 70);
        @(negedge clk) begin
            check("overrun_sticky", 64'(overrun), 64'(OVR_EXP));
            check("final_busy", 64'(busy), 64'(0));
            check("left_writes", 64'(exp_wr.size()), 64'(0));
            check("left_rd_en", 64'(exp_rd.size()), 64'(0));
            check("left_read_starts", 64'(exp_start.size()), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
